// File: rtl/cdc_pkg.sv
// Shared definitions for the two-phase (toggle) CDC handshake sender.
//   state_t          : sender FSM states
//   SYNC_STAGES_DEF  : default depth of the ack synchronizer
//   cnt_width()      : bit width of a counter that must hold 0..cyc
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam int unsigned SYNC_STAGES_DEF = 2;

  function automatic int unsigned cnt_width(input int unsigned cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// N-stage flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset (clears every stage)
//   d     in  asynchronous input
//   q     out synchronized output (last stage)
module cdc_sync_chain #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[N-2:0], d};
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of the two-phase toggle req/ack clock-domain crossing.
// A word accepted on in_valid/in_ready is held on data_out while req_out
// toggles; the transaction completes when the synchronized ack_in toggles.
// Optional macro CDC_TX_TIMEOUT_EN adds a sticky ack-timeout flag.
// Ports:
//   clk_src, rst_n_src : source clock, async active-low reset
//   in_valid/in_ready/in_data : upstream valid/ready word interface
//   req_out, data_out  : registered request toggle and held word
//   ack_in             : asynchronous ack toggle from destination
//   done               : one-cycle pulse on acknowledge
//   busy               : transaction outstanding
//   err_timeout        : sticky ack timeout (0 when macro undefined)
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_src,
  input  logic              rst_n_src,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              done,
  output logic              busy,
  output logic              err_timeout
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("cdc_handshake_tx: SYNC_STAGES must be 2..4 and TIMEOUT_CYC nonzero");
  end

  state_t state, state_next;
  logic   ack_sync;
  logic   ack_seen;
  logic   ack_edge;
  logic   accept;
  logic   ack_done;

  cdc_sync_chain #(.N(SYNC_STAGES)) u_ack_sync (
    .clk   (clk_src),
    .rst_n (rst_n_src),
    .d     (ack_in),
    .q     (ack_sync)
  );

  // ack_seen tracks the last ack parity consumed; any difference is a new toggle.
  assign ack_edge = ack_sync ^ ack_seen;
  assign accept   = in_ready & in_valid;
  assign ack_done = busy & ack_edge;

  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (in_valid) state_next = WAIT_ACK;
      WAIT_ACK: if (ack_edge) state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == WAIT_ACK);
  end

  // An ack toggle seen in IDLE only resynchronizes parity; it never pulses done.
  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      req_out  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      ack_seen <= 1'b0;
    end else begin
      done <= ack_done;
      if (ack_edge) ack_seen <= ack_sync;
      if (accept) begin
        data_out <= in_data;
        req_out  <= ~req_out;
      end
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  localparam int unsigned      CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] to_cnt;

  // Flag rises on the edge where the saturating count reaches the limit;
  // completion of the transaction takes priority and clears it.
  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt <= '0;
      end else if (busy && to_cnt != TO_LIMIT) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
      if (ack_done) begin
        err_timeout <= 1'b0;
      end else if (busy && to_cnt >= TO_LIMIT - CNT_W'(1)) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
`timescale 1ns/1ps
module tb_cdc_handshake_tx;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned TO_CYC = 16;
`ifdef CDC_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              ack_in;
  logic              done;
  logic              busy;
  logic              err_timeout;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk_src     (clk),
    .rst_n_src   (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .req_out     (req_out),
    .data_out    (data_out),
    .ack_in      (ack_in),
    .done        (done),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: ack_in is seen after a fixed delay line of SYNC samples;
  // a transaction is one outstanding word that ends when the delayed ack
  // parity differs from the last parity consumed.
  bit              m_busy, m_req, m_done, m_err, m_seen;
  logic [DATA_W-1:0] m_data;
  int unsigned     m_cnt;
  bit              sync_q[$];

  always @(posedge clk or negedge rst_n) begin
    bit cur_sync;
    bit toggled;
    if (!rst_n) begin
      m_busy = 0; m_req = 0; m_done = 0; m_err = 0; m_seen = 0;
      m_data = '0; m_cnt = 0;
      sync_q.delete();
      for (int i = 0; i < int'(SYNC); i++) sync_q.push_back(1'b0);
    end else begin
      cur_sync = sync_q.pop_front();
      sync_q.push_back(ack_in);
      toggled = (cur_sync != m_seen);
      m_done  = 0;
      if (m_busy) begin
        if (m_cnt < TO_CYC) m_cnt = m_cnt + 1;
        if (toggled) begin
          m_seen = cur_sync; m_busy = 0; m_done = 1; m_err = 0;
        end else if (TO_EN && m_cnt >= TO_CYC) begin
          m_err = 1;
        end
      end else begin
        if (toggled) m_seen = cur_sync;
        if (in_valid) begin
          m_data = in_data; m_req = !m_req; m_busy = 1; m_cnt = 0;
        end
      end
    end
  end

  bit              chk_en = 0;
  bit              prev_busy = 0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("busy",     32'(busy),     32'(m_busy));
      check("req_out",  32'(req_out),  32'(m_req));
      check("data_out", 32'(data_out), 32'(m_data));
      check("done",     32'(done),     32'(m_done));
      check("err",      32'(err_timeout), 32'(m_err));
      if (prev_busy && busy) check("data_hold", 32'(data_out), 32'(prev_data));
      prev_busy = busy;
      prev_data = data_out;
    end
  end

  // Destination stand-in: toggles ack_in resp_delay cycles after each req toggle.
  bit resp_en = 0;
  int resp_delay = 3;
  int manual_req = 0;
  int manual_done = 0;
  bit last_req = 0;
  bit pend = 0;
  int pcnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ack_in = 1'b0; last_req = 0; pend = 0; manual_done = manual_req;
    end else begin
      if (req_out != last_req) begin
        last_req = req_out;
        if (resp_en) begin pend = 1; pcnt = resp_delay; end
      end
      if (!resp_en) pend = 0;
      if (pend) begin
        if (pcnt == 0) begin ack_in = !ack_in; pend = 0; end
        else pcnt--;
      end
      if (manual_done != manual_req) begin
        ack_in = !ack_in;
        manual_done = manual_req;
      end
    end
  end

  task automatic wait_done(input int max, input string tag);
    bit seen = 0;
    for (int c = 0; c < max; c++) begin
      tick();
      if (done) begin seen = 1; break; end
    end
    check(tag, 32'(seen), 1);
  endtask

  logic [DATA_W-1:0] words [3] = '{8'h01, 8'h02, 8'h03};

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  ndone, nacc, nd;
    bit  req_prev, got;

    in_valid = 0; in_data = '0; rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    chk_en = 1;
    check("rst_ready", 32'(in_ready), 1);
    check("rst_busy",  32'(busy), 0);
    check("rst_req",   32'(req_out), 0);
    check("rst_data",  32'(data_out), 0);
    check("rst_done",  32'(done), 0);
    check("rst_err",   32'(err_timeout), 0);

    // Single transfer with a hand-timed ack
    in_data = 8'hA5; in_valid = 1;
    tick();
    in_valid = 0;
    check("a5_data", 32'(data_out), 'hA5);
    check("a5_req",  32'(req_out), 1);
    check("a5_busy", 32'(busy), 1);
    repeat (4) tick();
    manual_req++;
    tick(); check("a5_done_e5", 32'(done), 0);
    tick(); check("a5_done_e6", 32'(done), 0);
    tick(); check("a5_done_e7", 32'(done), 1);
    check("a5_ready_e7", 32'(in_ready), 1);
    tick(); check("a5_done_e8", 32'(done), 0);

    // Back-to-back with in_valid held
    resp_en = 1; resp_delay = 3;
    ndone = 0; nacc = 0; req_prev = req_out;
    in_data = words[0]; in_valid = 1;
    for (int c = 0; c < 200 && ndone < 3; c++) begin
      tick();
      if (done) ndone++;
      if (req_out != req_prev) begin
        req_prev = req_out;
        if (nacc < 3) check("b2b_data", 32'(data_out), 32'(words[nacc]));
        nacc++;
        if (nacc < 3) in_data = words[nacc];
        else in_valid = 0;
      end
    end
    in_valid = 0;
    check("b2b_accepts", nacc, 3);
    check("b2b_dones", ndone, 3);

    // Backpressure: a word offered while busy waits for the done cycle
    resp_delay = 6;
    in_data = 8'h11; in_valid = 1;
    tick();
    check("bp_first", 32'(data_out), 'h11);
    in_data = 8'h7E;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) begin
        check("bp_ready_on_done", 32'(in_ready), 1);
        check("bp_data_on_done", 32'(data_out), 'h11);
        tick();
        check("bp_accepted", 32'(data_out), 'h7E);
        check("bp_busy", 32'(busy), 1);
        got = 1;
        break;
      end
      check("bp_hold", 32'(data_out), 'h11);
    end
    check("bp_seen_done", 32'(got), 1);
    in_valid = 0;
    wait_done(30, "bp_second_done");
    tick();

    // Spurious ack while idle
    resp_en = 0;
    manual_req++;
    nd = 0;
    repeat (6) begin
      tick();
      if (done) nd++;
      check("spur_idle", 32'(in_ready), 1);
    end
    check("spur_nodone", nd, 0);
    resp_en = 1; resp_delay = 2;
    in_data = 8'h5A; in_valid = 1;
    tick();
    in_valid = 0;
    check("spur_next_data", 32'(data_out), 'h5A);
    wait_done(20, "spur_next_done");
    tick();

    // Asynchronous reset mid-transaction
    resp_en = 0;
    in_data = 8'hC3; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    check("mid_busy", 32'(busy), 1);
    #1 rst_n = 0;
    #1;
    check("arst_req",   32'(req_out), 0);
    check("arst_busy",  32'(busy), 0);
    check("arst_ready", 32'(in_ready), 1);
    check("arst_done",  32'(done), 0);
    check("arst_data",  32'(data_out), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    tick();

    // Ack timeout
    in_data = 8'h99; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (15) tick();
    check("to_err_15", 32'(err_timeout), 0);
    tick();
    check("to_err_16", 32'(err_timeout), 32'(TO_EN));
    check("to_busy_16", 32'(busy), 1);
    repeat (5) tick();
    check("to_sticky", 32'(err_timeout), 32'(TO_EN));
    check("to_busy_21", 32'(busy), 1);
    manual_req++;
    wait_done(10, "to_done");
    check("to_cleared", 32'(err_timeout), 0);
    tick();

    // Randomized traffic against the model
    resp_en = 1;
    for (int i = 0; i < 400; i++) begin
      resp_delay = int'($urandom_range(0, 5));
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = DATA_W'($urandom);
      tick();
    end
    in_valid = 0;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (in_ready) begin got = 1; break; end
    end
    check("rand_drain", 32'(got), 1);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-side sender of the team's two-phase (toggle) request/acknowledge clock-domain-crossing handshake. Accepts one data word per transaction through a valid/ready interface. Holds the word stable on a data bus, toggles a request line, and waits for the destination's acknowledge toggle. The acknowledge arrives asynchronously and is double-synchronized internally. The destination side uses the team's existing 2-flop receiver to synchronize req_out.

Parameters:
DATA_W, 8, width of the transferred word
SYNC_STAGES, 2, flops in the ack synchronizer chain (legal range 2..4)
TIMEOUT_CYC, 1024, ack timeout in clk_src cycles (used only with CDC_TX_TIMEOUT_EN)

Ports:
clk_src  in  1  source-domain clock
rst_n_src  in  1  reset, asynchronous assert, active-low
in_valid  in  1  upstream word available
in_ready  out  1  block can accept a word
in_data  in  DATA_W  upstream word
req_out  out  1  request toggle to destination; registered, glitch-free
data_out  out  DATA_W  held word to destination; registered
ack_in  in  1  asynchronous ack toggle from destination
done  out  1  one-cycle pulse when the transaction is acknowledged
busy  out  1  transaction outstanding
err_timeout  out  1  sticky ack-timeout flag (0 without macro)

Behaviour:
- Reset (rst_n_src low, asynchronous): state=IDLE; req_out=0, data_out=0, done=0, busy=0, err_timeout=0; sync chain=0; ack_seen=0; in_ready=1 after reset release.
- in_ready = (state==IDLE). busy = (state==WAIT_ACK). Both decoded from a registered state, never combinationally from in_valid or ack.
- ack_sync = last stage of the SYNC_STAGES-flop chain on ack_in. ack_edge = ack_sync ^ ack_seen.
- IDLE: on in_valid&&in_ready at edge N:
  - data_out<=in_data
  - req_out<=~req_out
  - state<=WAIT_ACK
  - req_out and data_out change on the same edge. data_out is frozen until the next accept.
- WAIT_ACK: on ack_edge:
  - ack_seen<=ack_sync
  - done<=1 for exactly one cycle
  - state<=IDLE
  - in_ready is high the cycle done is high.
  - in_valid held high accepts the next word on that same edge, giving back-to-back transactions.
- Latency: an ack_in toggle becomes visible as done SYNC_STAGES+1 clk_src edges later. Minimum round trip is set by the destination.
- in_valid while busy: ignored; the upstream word must be held (standard valid/ready).
- Spurious ack_edge in IDLE: ack_seen<=ack_sync (resynchronize parity), no done, no state change.
- Reset mid-transaction: everything returns to reset values. The destination must be reset in the same reset domain; parity is not preserved across reset.
- data_out stability: never changes while busy; a bench assertion checks this.

Optional Feature:
Macro CDC_TX_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYC+1)-bit counter clears on accept and increments each cycle in WAIT_ACK, saturating.
  - On reaching TIMEOUT_CYC, err_timeout<=1 (sticky). The state remains WAIT_ACK and the transaction is not aborted.
  - err_timeout clears on the cycle done pulses, or on reset.
- Undefined: no counter is built; err_timeout is tied to 0.

Decomposition:
- Package cdc_pkg:
  - state enum {IDLE, WAIT_ACK}
  - default SYNC_STAGES constant
  - width helper function for the timeout counter
- Sub-module cdc_sync_chain: parameterized N-stage synchronizer with active-low async reset. One instance is used for ack_in.

Test Plan:
- Reset: drive rst_n_src=0 mid-WAIT_ACK -> req_out=0, busy=0, in_ready=1, done=0 immediately (asynchronous), state IDLE.
- Single transfer, SYNC_STAGES=2: in_data=8'hA5 with in_valid at edge 0 -> data_out=A5 and req_out 0->1 at edge 0. Toggle ack_in to 1 before edge 5 -> done=1 on the cycle after edge 7 only; in_ready=1 in that cycle.
- Back-to-back: in_valid held with words 8'h01, 8'h02, 8'h03 and an ack responder at 3-cycle delay -> req_out toggles 3 times, data_out sequence 01,02,03, three done pulses, data_out never changes while busy.
- Backpressure: assert in_valid with 8'h7E while busy -> not accepted, data_out unchanged. Accepted on the cycle done pulses.
- Spurious ack: toggle ack_in while IDLE -> no done, no state change. The next transfer then completes normally on its own ack toggle.
- Timeout (macro defined, TIMEOUT_CYC=16): never toggle ack -> err_timeout=1 at 16 cycles after accept, busy stays 1. A later ack toggle -> done pulse and err_timeout=0.
